// File: rtl/bn_param_grad_accum_if.sv
// Stream, result and control bundle for the
// batch-norm parameter gradient accumulator.
interface bn_param_grad_accum_if #(
  parameter int BIT_WIDTH = 16,
  parameter int CHANNELS  = 32
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                 start;
  logic                 busy;
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] in_dy;
  logic [BIT_WIDTH-1:0] in_xhat;
  logic                 out_valid;
  logic                 out_ready;
  logic [CW-1:0]        out_channel;
  logic [BIT_WIDTH-1:0] out_dgamma;
  logic [BIT_WIDTH-1:0] out_dbeta;
  logic                 done;

  modport master (
    output start, in_valid, in_dy, in_xhat, out_ready,
    input  busy, in_ready, out_valid, out_channel,
    input  out_dgamma, out_dbeta, done
  );

  modport slave (
    input  start, in_valid, in_dy, in_xhat, out_ready,
    output busy, in_ready, out_valid, out_channel,
    output out_dgamma, out_dbeta, done
  );
endinterface

// File: rtl/bn_param_grad_accum.sv
// Per-channel dgamma/dbeta accumulation for the
// batch-norm backward pass, drained one channel per beat.
module bn_param_grad_accum #(
  parameter int CHANNELS     = 32,
  parameter int FEATURE_SIZE = 32,
  parameter int BIT_WIDTH    = 16,
  parameter int FRAC_BITS    = 8,
  parameter int ACC_WIDTH    = 40
) (
  input logic clk,
  input logic rst,
  bn_param_grad_accum_if.slave bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int N_ELEM = FEATURE_SIZE * FEATURE_SIZE * CHANNELS;
  localparam int EW = $clog2(N_ELEM + 1);
  localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);
  localparam logic [EW-1:0] EL_LAST = EW'(N_ELEM - 1);
  localparam logic signed [ACC_WIDTH-1:0] SMAX =
    {{(ACC_WIDTH-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SMIN =
    {{(ACC_WIDTH-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        ch_q, ch_d, ch_nxt;
  logic [EW-1:0]        elem_q, elem_d;
  logic [CW-1:0]        out_ch_q, out_ch_d;
  logic [BIT_WIDTH-1:0] out_dg_q, out_dg_d;
  logic [BIT_WIDTH-1:0] out_db_q, out_db_d;
  logic                 done_q, done_d;

  logic signed [ACC_WIDTH-1:0] dg_mem [CHANNELS];
  logic signed [ACC_WIDTH-1:0] db_mem [CHANNELS];

  logic                          accept;
  logic                          wr_en;
  logic signed [2*BIT_WIDTH-1:0] prod;
  logic signed [2*BIT_WIDTH-1:0] prod_sh;
  logic signed [ACC_WIDTH-1:0]   wr_dg, wr_db;
  logic signed [ACC_WIDTH-1:0]   ld_dg, ld_db;
  logic [CW-1:0]                 ld_idx;

  function automatic logic [BIT_WIDTH-1:0] sat(
    input logic signed [ACC_WIDTH-1:0] a
  );
    if (a > SMAX) return SMAX[BIT_WIDTH-1:0];
    if (a < SMIN) return SMIN[BIT_WIDTH-1:0];
    return a[BIT_WIDTH-1:0];
  endfunction

  assign accept  = bus.in_valid && (state_q == ACCUM);
  assign ch_nxt  = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
  assign prod    = $signed(bus.in_dy) * $signed(bus.in_xhat);
  assign prod_sh = prod >>> FRAC_BITS;

  // Accumulator write port: zero fill in CLEAR, RMW in ACCUM.
  always_comb begin
    wr_en = 1'b0;
    wr_dg = '0;
    wr_db = '0;
    if (state_q == CLEAR) begin
      wr_en = 1'b1;
    end else if (accept) begin
      wr_en = 1'b1;
      wr_dg = dg_mem[ch_q] + ACC_WIDTH'(prod_sh);
      wr_db = db_mem[ch_q] + ACC_WIDTH'($signed(bus.in_dy));
    end
  end

  // Result fetch, forwarding the last beat's sum into DRAIN.
  always_comb begin
    ld_idx = (state_q == DRAIN) ? ch_nxt : '0;
    if (wr_en && ch_q == ld_idx) begin
      ld_dg = wr_dg;
      ld_db = wr_db;
    end else begin
      ld_dg = dg_mem[ld_idx];
      ld_db = db_mem[ld_idx];
    end
  end

  // Accumulator storage; contents are defined by CLEAR.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      dg_mem[ch_q] <= wr_dg;
      db_mem[ch_q] <= wr_db;
    end
  end

  // Pass sequencing and registered result beat.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    elem_d   = elem_q;
    out_ch_d = out_ch_q;
    out_dg_d = out_dg_q;
    out_db_d = out_db_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CLEAR;
          ch_d    = '0;
        end
      end
      CLEAR: begin
        ch_d = ch_nxt;
        if (ch_q == CH_LAST) begin
          state_d = ACCUM;
          elem_d  = '0;
        end
      end
      ACCUM: begin
        if (accept) begin
          ch_d   = ch_nxt;
          elem_d = elem_q + 1'b1;
          if (elem_q == EL_LAST) begin
            state_d  = DRAIN;
            ch_d     = '0;
            out_ch_d = '0;
            out_dg_d = sat(ld_dg);
            out_db_d = sat(ld_db);
          end
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          ch_d     = ch_nxt;
          out_ch_d = ch_nxt;
          out_dg_d = sat(ld_dg);
          out_db_d = sat(ld_db);
          if (ch_q == CH_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      elem_q   <= '0;
      out_ch_q <= '0;
      out_dg_q <= '0;
      out_db_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      elem_q   <= elem_d;
      out_ch_q <= out_ch_d;
      out_dg_q <= out_dg_d;
      out_db_q <= out_db_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.in_ready    = (state_q == ACCUM);
  assign bus.out_valid   = (state_q == DRAIN);
  assign bus.out_channel = out_ch_q;
  assign bus.out_dgamma  = out_dg_q;
  assign bus.out_dbeta   = out_db_q;
  assign bus.done        = done_q;
endmodule
